hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked stages after decode (index 0 = EX ... DEPTH-1 = WB), legal 2..8.
REQ-002 SHALL have parameter LOAD_FWD_IDX, default 2, lowest stage index from which a load result can be forwarded, legal 1..DEPTH-1.
REQ-003 SHALL have parameter RBITS, default 5, register address width.
REQ-004 SHALL have parameter CNTW, default 16, stall counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous reset, active low.
REQ-007 id_valid  in  1  decode stage holds a real instruction.
REQ-008 id_rs1, id_rs2  in  RBITS each  source register addresses.
REQ-009 id_rs1_used, id_rs2_used  in  1 each  source actually read.
REQ-010 id_rd  in  RBITS  destination address; id_rd_wen  in  1  instruction writes rd.
REQ-011 id_is_load  in  1  instruction is a load.
REQ-012 flush_i  in  1  taken branch/jump resolved in EX; kill decode instruction.
REQ-013 stall_o  out  1  hold PC and IF/ID registers this cycle.
REQ-014 ex_valid_o  out  1  EX stage holds a real (non-bubble) instruction.
REQ-015 fwd_a_o, fwd_b_o  out  $clog2(DEPTH) each  operand source for EX: 0 = register file, k = result of stage k.
REQ-016 stall_cnt_o  out  CNTW  saturating count of load-use stall cycles.

Function
REQ-017 SHALL keep a DEPTH-entry tracker; each entry = {valid, rd, wen, is_load}; it shifts one index every cycle unconditionally; entry DEPTH-1 retires.
REQ-018 Entry 0 SHALL load the decode instruction when id_valid & !stall_o & !flush_i, otherwise a bubble (valid=0).
REQ-019 A source SHALL match entry i (i in 0..DEPTH-2) when used, entry valid, wen=1, rd!=0 and rd==rs; entry DEPTH-1 is never checked (regfile already written).
REQ-020 With several matches the lowest index (youngest) SHALL win.
REQ-021 Winning match at i SHALL yield forward source k=i+1.
REQ-022 stall_o SHALL be combinational: 1 when id_valid & !flush_i and either source wins on a load entry with i+1 < LOAD_FWD_IDX; else 0.
REQ-023 Non-load matches SHALL never stall.
REQ-024 fwd_a_o/fwd_b_o SHALL be registered: on an advancing cycle (REQ-018 load condition) capture k (or 0 if no match/unused); on bubble cycles capture 0.
REQ-025 ex_valid_o SHALL equal entry 0 valid.
REQ-026 flush_i SHALL override stall: stall_o=0, bubble into entry 0, fwd outputs captured 0, no counter increment.
REQ-027 stall_cnt_o SHALL increment by 1 each cycle stall_o=1 and hold at 2^CNTW-1.
REQ-028 Stall SHALL be re-evaluated every cycle; with LOAD_FWD_IDX=L a load immediately followed by its consumer SHALL stall L-1 cycles.
REQ-029 Both operands matching different entries SHALL forward independently; same entry SHALL give equal selects.

Reset
REQ-030 rst_n=0 at an edge SHALL clear all tracker entries to invalid, fwd_a_o=fwd_b_o=0, stall_cnt_o=0, ex_valid_o=0, regardless of stall or flush in progress.
REQ-031 stall_o SHALL be forced 0 while rst_n=0.
REQ-032 First cycle after rst_n rises SHALL behave as an empty pipeline (no matches).

Verification (DEPTH=3, LOAD_FWD_IDX=2)
REQ-033 add x5 then next cycle add using rs1=x5 -> no stall; consumer in EX with fwd_a_o=1.
REQ-034 add x5, bubble, consumer rs2=x5 -> fwd_b_o=2; add x5 then 2 bubbles then consumer -> fwd_b_o=0.
REQ-035 lw x5 then consumer rs1=x5 -> stall_o=1 for exactly 1 cycle, ex_valid_o=0 next cycle, then consumer in EX with fwd_a_o=2; stall_cnt_o=1.
REQ-036 writer rd=x0 (wen=1, load) then consumer rs1=x0 -> no stall, fwd_a_o=0; add x5 then add x5 then consumer x5 -> fwd_a_o=1 (youngest).
REQ-037 load-use stall cycle with flush_i=1 -> stall_o=0, ex_valid_o=0 next cycle, stall_cnt_o unchanged.
REQ-038 rst_n=0 during load-use stall -> next cycle all outputs 0; counter at 2^16-1 holds under further stalls.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Load-use hazard detection and EX operand forwarding select.
// Tracks in-flight destinations per stage and picks the youngest producer.
module hazard_fwd_unit #(
    parameter int DEPTH        = 3,
    parameter int LOAD_FWD_IDX = 2,
    parameter int RBITS        = 5,
    parameter int CNTW         = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [RBITS-1:0]           id_rs1,
    input  logic [RBITS-1:0]           id_rs2,
    input  logic                       id_rs1_used,
    input  logic                       id_rs2_used,
    input  logic [RBITS-1:0]           id_rd,
    input  logic                       id_rd_wen,
    input  logic                       id_is_load,
    input  logic                       flush_i,
    output logic                       stall_o,
    output logic                       ex_valid_o,
    output logic [$clog2(DEPTH)-1:0]   fwd_a_o,
    output logic [$clog2(DEPTH)-1:0]   fwd_b_o,
    output logic [CNTW-1:0]            stall_cnt_o
);

    localparam int FW = $clog2(DEPTH);

    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            wen_q, wen_d;
    logic [DEPTH-1:0]            ld_q, ld_d;
    logic [DEPTH-1:0][RBITS-1:0] rd_q, rd_d;
    logic [FW-1:0]               fwd_a_q, fwd_a_d;
    logic [FW-1:0]               fwd_b_q, fwd_b_d;
    logic [CNTW-1:0]             cnt_q, cnt_d;

    logic [FW-1:0] sel_a, sel_b;
    logic          stl_a, stl_b;
    logic          adv;

    // Scan oldest to youngest so the youngest producer overwrites the select.
    // The last entry has already written the regfile and is never matched.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        stl_a = 1'b0;
        stl_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i < DEPTH - 1 && v_q[i] && wen_q[i] && rd_q[i] != '0) begin
                if (id_rs1_used && rd_q[i] == id_rs1) begin
                    sel_a = FW'(i + 1);
                    stl_a = ld_q[i] && (i + 1 < LOAD_FWD_IDX);
                end
                if (id_rs2_used && rd_q[i] == id_rs2) begin
                    sel_b = FW'(i + 1);
                    stl_b = ld_q[i] && (i + 1 < LOAD_FWD_IDX);
                end
            end
        end
    end

    assign stall_o = rst_n && id_valid && !flush_i && (stl_a || stl_b);
    assign adv     = id_valid && !stall_o && !flush_i;

    always_comb begin
        v_d     = {v_q[DEPTH-2:0], adv};
        wen_d   = {wen_q[DEPTH-2:0], id_rd_wen};
        ld_d    = {ld_q[DEPTH-2:0], id_is_load};
        rd_d    = {rd_q[DEPTH-2:0], id_rd};
        fwd_a_d = adv ? sel_a : '0;
        fwd_b_d = adv ? sel_b : '0;
        cnt_d   = cnt_q;
        if (stall_o && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= '0;
            wen_q   <= '0;
            ld_q    <= '0;
            rd_q    <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
            cnt_q   <= '0;
        end else begin
            v_q     <= v_d;
            wen_q   <= wen_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o  = v_q[0];
    assign fwd_a_o     = fwd_a_q;
    assign fwd_b_o     = fwd_b_q;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed per-cycle vectors.
// A second instance with a 4-bit counter exercises saturation.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_rd_wen, id_is_load, flush_i;

    logic        stall, exv, stall_s, exv_s;
    logic [1:0]  fa, fb, fa_s, fb_s;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
        .flush_i(flush_i), .stall_o(stall), .ex_valid_o(exv),
        .fwd_a_o(fa), .fwd_b_o(fb), .stall_cnt_o(cnt)
    );

    hazard_fwd_unit #(.CNTW(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
        .flush_i(flush_i), .stall_o(stall_s), .ex_valid_o(exv_s),
        .fwd_a_o(fa_s), .fwd_b_o(fb_s), .stall_cnt_o(cnt_s)
    );

    typedef struct {
        logic        st;
        logic        exv;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
        logic [3:0]  cnts;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    task automatic chk(input string n, input int act, input int ex);
        tests++;
        if (act != ex) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, ex);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("stall", int'(stall), int'(e.st));
                chk("ex_valid", int'(exv), int'(e.exv));
                chk("fwd_a", int'(fa), int'(e.fa));
                chk("fwd_b", int'(fb), int'(e.fb));
                chk("stall_cnt", int'(cnt), int'(e.cnt));
                chk("sat_stall", int'(stall_s), int'(e.st));
                chk("sat_ex_valid", int'(exv_s), int'(e.exv));
                chk("sat_fwd_a", int'(fa_s), int'(e.fa));
                chk("sat_fwd_b", int'(fb_s), int'(e.fb));
                chk("sat_cnt", int'(cnt_s), int'(e.cnts));
            end
        end
    end

    task automatic step(
        input logic rn, input logic v,
        input logic [4:0] r1, input logic u1,
        input logic [4:0] r2, input logic u2,
        input logic [4:0] rd, input logic w, input logic ld, input logic fl,
        input logic est, input logic eexv,
        input logic [1:0] efa, input logic [1:0] efb);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; id_valid = v;
        id_rs1 = r1; id_rs1_used = u1;
        id_rs2 = r2; id_rs2_used = u2;
        id_rd = rd; id_rd_wen = w; id_is_load = ld; flush_i = fl;
        e.st   = est;
        e.exv  = eexv;
        e.fa   = efa;
        e.fb   = efb;
        e.cnt  = 16'(exp_cnt);
        e.cnts = (exp_cnt > 15) ? 4'd15 : 4'(exp_cnt);
        q.push_back(e);
        if (!rn)      exp_cnt = 0;
        else if (est) exp_cnt++;
    endtask

    task automatic ins(
        input logic [4:0] r1, input logic u1,
        input logic [4:0] r2, input logic u2,
        input logic [4:0] rd, input logic w, input logic ld, input logic fl,
        input logic est, input logic eexv,
        input logic [1:0] efa, input logic [1:0] efb);
        step(1'b1, 1'b1, r1, u1, r2, u2, rd, w, ld, fl, est, eexv, efa, efb);
    endtask

    task automatic nop(input logic eexv, input logic [1:0] efa,
                       input logic [1:0] efb);
        step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0,
             1'b0, eexv, efa, efb);
    endtask

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; flush_i = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_rd_wen = 1'b0; id_is_load = 1'b0;
        repeat (2) @(posedge clk);

        // reset state with a load presented
        step(0, 1, 5, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        // add x5 -> consumer rs1: fwd 1
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        ins(5, 1, 0, 0, 6, 1, 0, 0, 0, 1, 0, 0);
        nop(1, 1, 0);
        // add x5, bubble, consumer rs2: fwd 2
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 0);
        ins(0, 0, 5, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 2);
        // add x5, two bubbles, consumer: regfile
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 0);
        nop(0, 0, 0);
        ins(0, 0, 5, 1, 7, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 0, 0);
        // lw x5 -> consumer: one stall, then fwd 2
        ins(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        ins(5, 1, 0, 0, 8, 1, 0, 0, 1, 1, 0, 0);
        ins(5, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        nop(1, 2, 0);
        // load to x0 then consumer x0: nothing
        ins(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        ins(0, 1, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0);
        // two writers of x5: youngest wins
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0);
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 1, 0, 0);
        ins(5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        nop(1, 1, 0);
        // independent and shared operand selects
        ins(0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0);
        ins(0, 0, 0, 0, 7, 1, 0, 0, 0, 1, 0, 0);
        ins(6, 1, 7, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        ins(7, 1, 7, 1, 0, 0, 0, 0, 0, 1, 2, 1);
        nop(1, 2, 2);
        // flush overrides load-use stall
        ins(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        ins(5, 1, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0);
        nop(0, 0, 0);
        // flush on a forwarding consumer captures 0
        ins(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
        ins(5, 1, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0);
        nop(0, 0, 0);
        // reset during a load-use hazard
        ins(0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        ins(5, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0);
        ins(8, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // reset clears a nonzero forward select
        step(0, 1, 8, 1, 8, 1, 8, 1, 1, 0, 0, 1, 1, 0);
        nop(0, 0, 0);
        // repeated load-use pairs: 17 stalls saturate the 4-bit counter
        for (int r = 0; r < 17; r++) begin
            ins(0, 0, 0, 0, 5, 1, 1, 0, 0, (r != 0), (r != 0) ? 2'd2 : 2'd0, 0);
            ins(5, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            ins(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        nop(1, 2, 0);
        nop(0, 0, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
